alu_exec_ctrl: RTL
==================

# alu_exec_ctrl

Execute-stage controller that drives the 32-bit ALU and consumes its results. It decodes the instruction, forms ALU operands, opcode and shift amount, and registers the ALU result into the X/M pipeline register behind a valid/ready handshake. It also resolves `bne`/`blt` branches from the ALU flags, squashes one wrong-path beat after a taken branch, and rewrites overflowing arithmetic into `$r30` status writes.

## Interface
- No parameters. Widths are fixed: 32-bit data, 5-bit register and opcode fields.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `in_valid` in 1 / `in_ready` out 1: D/X beat handshake.
- `in_insn` in 32: instruction; opcode[31:27], rd[26:22], rs[21:17], rt[16:12], shamt[11:7], aluop[6:2], imm[16:0].
- `in_pc` in 32: PC of `in_insn`.
- `in_regA`, `in_regB` in 32: source values. R/I-type: A=$rs, B=$rt. Branches: A=$rd, B=$rs.
- `alu_operandA`, `alu_operandB` out 32, `alu_opcode` out 5, `alu_shamt` out 5: combinational drive to the ALU.
- `alu_result` in 32, `alu_isNotEqual` in 1 (unused), `alu_isLessThan` in 1, `alu_overflow` in 1: ALU outputs.
- `out_valid` out 1 / `out_ready` in 1: X/M beat handshake.
- `out_result` out 32, `out_rd` out 5, `out_we` out 1: writeback payload.
- `br_taken` out 1, `br_target` out 32: branch redirect, qualified by `out_valid`.

## Operation
- Decode (combinational; `alu_shamt` = shamt):
  - R-type, opcode 00000: `alu_opcode` = aluop; B = `in_regB`. Valid aluop values are 00000–00101 (add, sub, and, or, sll, sra). Any other aluop is a NOP.
  - addi, opcode 00101: `alu_opcode` = 00000; B = sign-extended imm[16:0].
  - bne 00010 / blt 00110: `alu_opcode` = 00001; B = `in_regB`; `we` = 0.
  - Any other opcode: NOP. A NOP is still a beat, with `we` = 0, result 0, `br_taken` = 0.
- `alu_operandA` = `in_regA` always.
- Branch resolution:
  - equal = (`alu_result` == 0). `alu_isNotEqual` is ignored because it is wrong when an operand is zero.
  - less = `alu_isLessThan` XOR `alu_overflow`.
  - bne is taken when !equal. blt is taken when less (i.e. $rd < $rs).
  - `br_target` = `in_pc` + 1 + sext(imm), modulo 2^32.
- Writeback: `out_we` = 1 for valid R-type and addi only, and forced 0 when rd = 0.
- States:
  - RUN: normal operation.
  - SQUASH: entered on the cycle a taken branch is captured. Exits to RUN after exactly one input beat is accepted and discarded. That beat produces no output and cannot itself branch. SQUASH persists while no beat arrives.
- Reset mid-operation: immediate return to RUN. Output register cleared. Any pending squash is forgotten.

## Timing
- Reset values: `out_valid` 0, `out_result` 0, `out_rd` 0, `out_we` 0, `br_taken` 0, `br_target` 0, state RUN.
- `in_ready` = !`out_valid` || `out_ready`. In SQUASH, `in_ready` follows the same rule.
- Capture occurs on the rising edge where `in_valid` && `in_ready` in RUN. Latency is 1 cycle: the payload appears with `out_valid` on the next cycle.
- Stall: while `out_valid` && !`out_ready`, all `out_*` and `br_*` hold stable, and `in_ready` = 0.
- Simultaneous consume and capture: when the downstream consumes and a new beat arrives in the same cycle, the register reloads with no bubble.
- If `in_valid` = 0 on a consuming edge, `out_valid` drops to 0. `br_taken` is meaningful only while `out_valid` = 1 and stays high until that beat is consumed.
- In SQUASH, a discarded beat clears `out_valid` if the prior beat was consumed on the same edge.

## Configuration
- `ALU_EXEC_OVF_EXC_EN` defined: overflow exceptions are enabled. Add, addi or sub with `alu_overflow` = 1 writes `out_rd` = 30, `out_we` = 1, and `out_result` = 1 for add, 2 for addi, 3 for sub.
- `ALU_EXEC_OVF_EXC_EN` undefined: overflow is ignored. The wrapped ALU result is written to rd as normal.
- Branches use `alu_overflow` in either configuration.

## Test plan
- Reset, then add: A=5, B=7, rd=3 → next cycle `out_valid`=1, `out_result`=12, `out_rd`=3, `out_we`=1, `br_taken`=0.
- addi: imm=0x1FFFF, A=10 → `out_result`=9. Then add with A=0x7FFFFFFF, B=1, rd=4 → with the macro: rd=30, result=1; without it: rd=4, result=0x80000000.
- blt: A=0x80000000, B=1, pc=100, imm=−5 → `br_taken`=1, `br_target`=96. The next accepted beat is discarded (no `out_valid`), and the beat after it is processed normally.
- bne: A=0, B=9 → taken. bne: A=9, B=9 → not taken, `out_we`=0.
- Back-pressure: hold `out_ready`=0 for 3 cycles with `in_valid`=1 → `in_ready`=0 and outputs stable. Release `out_ready` → back-to-back beats with no bubble.
- Assert `reset` while in SQUASH with `out_valid`=1 → all outputs return to 0 immediately. The first beat after reset is processed, not squashed.

Source files
------------

// File: rtl/alu_exec_ctrl_if.sv
// Interface for alu_exec_ctrl: D/X input beat, ALU drive/return, X/M output
// beat and branch redirect. The controller uses the slave view; the decode
// stage / ALU / memory stage side uses the master view.
interface alu_exec_ctrl_if;
  // D/X beat
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_insn;
  logic [31:0] in_pc;
  logic [31:0] in_regA;
  logic [31:0] in_regB;
  // ALU drive
  logic [31:0] alu_operandA;
  logic [31:0] alu_operandB;
  logic [4:0]  alu_opcode;
  logic [4:0]  alu_shamt;
  // ALU return
  logic [31:0] alu_result;
  logic        alu_isNotEqual;
  logic        alu_isLessThan;
  logic        alu_overflow;
  // X/M beat and branch redirect
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_we;
  logic        br_taken;
  logic [31:0] br_target;

  modport slave (
    input  in_valid, in_insn, in_pc, in_regA, in_regB,
    input  alu_result, alu_isNotEqual, alu_isLessThan, alu_overflow,
    input  out_ready,
    output in_ready, alu_operandA, alu_operandB, alu_opcode, alu_shamt,
    output out_valid, out_result, out_rd, out_we, br_taken, br_target
  );

  modport master (
    output in_valid, in_insn, in_pc, in_regA, in_regB,
    output alu_result, alu_isNotEqual, alu_isLessThan, alu_overflow,
    output out_ready,
    input  in_ready, alu_operandA, alu_operandB, alu_opcode, alu_shamt,
    input  out_valid, out_result, out_rd, out_we, br_taken, br_target
  );
endinterface

// File: rtl/alu_exec_ctrl.sv
// Execute-stage controller: decodes the instruction, drives the ALU, resolves
// bne/blt from ALU flags and registers the result into the X/M register.
// A taken branch squashes the next accepted input beat.
// Build option: define ALU_EXEC_OVF_EXC_EN to turn overflowing add/addi/sub
// into a status write of 1/2/3 to $r30; otherwise the wrapped sum is written.
module alu_exec_ctrl (
  input  logic         clock,
  input  logic         reset,
  alu_exec_ctrl_if.slave bus
);
  localparam logic [4:0] OP_RTYPE = 5'd0;
  localparam logic [4:0] OP_BNE   = 5'd2;
  localparam logic [4:0] OP_ADDI  = 5'd5;
  localparam logic [4:0] OP_BLT   = 5'd6;
  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_SRA  = 5'd5;

  typedef enum logic {RUN, SQUASH} state_t;

  state_t      state_q;
  logic        out_valid_q, out_we_q, br_taken_q;
  logic [31:0] out_result_q, br_target_q;
  logic [4:0]  out_rd_q;

  logic [4:0]  opc, rd, aluop;
  logic [31:0] simm;
  logic        is_r, is_addi, is_bne, is_blt, is_br;
  logic [31:0] res_d, target_d;
  logic [4:0]  rd_d;
  logic        we_d, taken_d, fire;
  logic        unused_ok;

  // isNotEqual is wrong when an operand is zero; equality comes from the result.
  assign unused_ok = bus.alu_isNotEqual;

  assign opc     = bus.in_insn[31:27];
  assign rd      = bus.in_insn[26:22];
  assign aluop   = bus.in_insn[6:2];
  assign simm    = {{15{bus.in_insn[16]}}, bus.in_insn[16:0]};
  assign is_r    = (opc == OP_RTYPE) && (aluop <= ALU_SRA);
  assign is_addi = (opc == OP_ADDI);
  assign is_bne  = (opc == OP_BNE);
  assign is_blt  = (opc == OP_BLT);
  assign is_br   = is_bne || is_blt;

  // ALU drive: branches compare via subtract, addi adds the sign-extended imm.
  assign bus.alu_operandA = bus.in_regA;
  assign bus.alu_operandB = is_addi ? simm : bus.in_regB;
  assign bus.alu_opcode   = is_r ? aluop : (is_br ? ALU_SUB : ALU_ADD);
  assign bus.alu_shamt    = bus.in_insn[11:7];

  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign fire         = bus.in_valid && bus.in_ready;

  // Next X/M payload from the ALU return; NOPs leave result 0 and we 0.
  always_comb begin
    res_d    = '0;
    rd_d     = rd;
    we_d     = 1'b0;
    taken_d  = 1'b0;
    target_d = bus.in_pc + 32'd1 + simm;
    if (is_r || is_addi) begin
      res_d = bus.alu_result;
      we_d  = (rd != 5'd0);
    end
    // blt: the raw sign flag is wrong on overflow, so correct it with ovf.
    if (is_bne) taken_d = (bus.alu_result != 32'd0);
    if (is_blt) taken_d = bus.alu_isLessThan ^ bus.alu_overflow;
`ifdef ALU_EXEC_OVF_EXC_EN
    if (bus.alu_overflow && (is_addi || (is_r && (aluop == ALU_ADD || aluop == ALU_SUB)))) begin
      rd_d  = 5'd30;
      we_d  = 1'b1;
      res_d = is_addi ? 32'd2 : ((aluop == ALU_ADD) ? 32'd1 : 32'd3);
    end
`endif
  end

  // Squash FSM and X/M output register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= RUN;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_rd_q     <= '0;
      out_we_q     <= 1'b0;
      br_taken_q   <= 1'b0;
      br_target_q  <= '0;
    end else begin
      case (state_q)
        RUN: begin
          if (fire) begin
            out_valid_q  <= 1'b1;
            out_result_q <= res_d;
            out_rd_q     <= rd_d;
            out_we_q     <= we_d;
            br_taken_q   <= taken_d;
            br_target_q  <= target_d;
            if (taken_d) state_q <= SQUASH;
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        SQUASH: begin
          // Wrong-path beat: accepted and dropped; any prior beat was consumed.
          if (fire) begin
            out_valid_q <= 1'b0;
            br_taken_q  <= 1'b0;
            state_q     <= RUN;
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = out_result_q;
  assign bus.out_rd     = out_rd_q;
  assign bus.out_we     = out_we_q;
  assign bus.br_taken   = br_taken_q;
  assign bus.br_target  = br_target_q;
endmodule
